addsub_multibyte_seq: RTL and testbench
=======================================

Name: addsub_multibyte_seq

Overview:
- Sequential controller that performs NBYTES-wide add/subtract by iterating one 8-bit add/sub slice over the operands, least significant byte first.
- Chains carry between bytes.
- Valid/ready operand input, valid/ready result output.
- Sits between the ALU issue logic and the byte-wide adder datapath. Trades latency for reuse of a single 8-bit adder.

Parameters:
- NBYTES, 4, number of 8-bit slices per operation; minimum 2.
- W, 8*NBYTES, derived operand width; not user-overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand/op valid
- in_ready  output  1  block can accept an operation
- op_a  input  W  minuend / addend A
- op_b  input  W  subtrahend / addend B
- sub  input  1  1 = A−B, 0 = A+B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  W  A±B, modulo 2^W
- carry_out  output  1  raw carry out of MSB; for sub, 1 = no borrow
- overflow  output  1  signed two's-complement overflow
- busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous, active-high, single clock:
  - state = IDLE, byte index = 0, carry register = 0.
  - result = 0, carry_out = 0, overflow = 0, out_valid = 0.
  - in_ready = 1 once rst deasserts; busy = 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch op_a, op_b and sub; go to RUN with idx = 0 and carry = sub (a subtract injects +1).
  - RUN, one byte per cycle:
    - slice inputs: a = A[8*idx +: 8], b = sub ? ~B byte : B byte, cin = carry.
    - store the sum byte into the result register; carry ← slice cout; idx++.
    - on idx == NBYTES−1, also capture carry_out and overflow, then go to DONE.
  - DONE: out_valid = 1. result, carry_out and overflow are stable. On out_ready, go to IDLE.
- Latency:
  - out_valid rises exactly NBYTES cycles after the accepting edge.
  - In IDLE with out_ready held high: back-to-back throughput is one operation per NBYTES+2 cycles.
- Handshake rules:
  - in_ready = 0 in RUN and DONE; in_valid is ignored there.
  - Operands are latched, so op_a, op_b and sub may change after acceptance.
  - out_valid stays high until out_ready. Result fields must not change while out_valid = 1.
  - Result fields retain their values after the output handshake until the next RUN overwrites them.
- Overflow: computed on the final byte as (cin into bit 7) XOR (cout of bit 7). Equivalently, a[7] == b_eff[7] and sum[7] != a[7].
- Wrap-around: result is modulo 2^W; no saturation.
- Simultaneous events: a DONE-state out_ready has no input-acceptance interaction, because in_ready = 0 in DONE. No same-cycle accept.
- rst asserted mid-RUN or mid-DONE: the operation is aborted and the result discarded; all outputs return to reset values immediately.

Decomposition:
- Shared package addsub_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - BYTE_W = 8
  - the NBYTES lower-bound check
- Sub-module addsub_byte_slice is purely combinational:
  - inputs: a[7:0], b[7:0], sub, cin
  - outputs: sum[7:0], cout, c7 (carry into bit 7)
  - the controller instantiates exactly one.

Test Plan (NBYTES=4):
- Add with byte carry: A=0x000000FF, B=0x00000001, sub=0 → result=0x00000100, carry_out=0, overflow=0; out_valid exactly 4 cycles after accept.
- Full-width carry: A=0xFFFFFFFF, B=0x00000001, sub=0 → result=0x00000000, carry_out=1, overflow=0.
- Signed overflow on add: A=0x7FFFFFFF, B=0x00000001, sub=0 → result=0x80000000, carry_out=0, overflow=1.
- Subtract with borrow and signed overflow:
  - A=0x00000000, B=0x00000001, sub=1 → result=0xFFFFFFFF, carry_out=0, overflow=0.
  - A=0x80000000, B=0x00000001, sub=1 → result=0x7FFFFFFF, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, result and flags constant; in_ready=0; in_valid pulses are ignored. out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst on the 2nd RUN cycle → out_valid=0, busy=0 and result=0 asynchronously. After release, a new 0x12345678+0x11111111 → result 0x23456789.

Source files
------------

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the multi-byte sequential add/subtract controller:
//   - BYTE_W      : width of the single adder slice that is reused every cycle
//   - MIN_NBYTES  : smallest legal operand size in bytes
//   - state_t     : controller state encoding
//   - nbytes_ok() : elaboration-time legality check for the NBYTES parameter
// -----------------------------------------------------------------------------
package addsub_pkg;

    localparam int BYTE_W     = 8;
    localparam int MIN_NBYTES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when the requested slice count is at least the supported minimum.
    function automatic bit nbytes_ok(input int n);
        return (n >= MIN_NBYTES);
    endfunction

endpackage

// File: rtl/addsub_byte_slice.sv
// -----------------------------------------------------------------------------
// addsub_byte_slice
// Purely combinational 8-bit add/subtract slice. For subtraction the B byte is
// inverted here; the +1 of the two's-complement negate is supplied by the
// caller through cin on the least significant byte.
// Ports:
//   a    [7:0] in  : A byte
//   b    [7:0] in  : raw B byte (inverted internally when sub = 1)
//   sub        in  : 1 = subtract, 0 = add
//   cin        in  : carry into bit 0
//   sum  [7:0] out : sum byte
//   cout       out : carry out of bit 7
//   c7         out : carry into bit 7 (used for signed overflow detection)
// -----------------------------------------------------------------------------
module addsub_byte_slice
    import addsub_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              c7
);

    logic [BYTE_W-1:0] w_b_eff;
    logic [BYTE_W-1:0] w_low;

    assign w_b_eff = sub ? ~b : b;

    // Add the low seven bits separately so the carry into bit 7 is exposed.
    assign w_low = {1'b0, a[BYTE_W-2:0]} + {1'b0, w_b_eff[BYTE_W-2:0]}
                 + {{(BYTE_W-1){1'b0}}, cin};

    assign c7   = w_low[BYTE_W-1];
    assign sum  = {a[BYTE_W-1] ^ w_b_eff[BYTE_W-1] ^ w_low[BYTE_W-1], w_low[BYTE_W-2:0]};
    assign cout = (a[BYTE_W-1] & w_b_eff[BYTE_W-1])
                | (w_low[BYTE_W-1] & (a[BYTE_W-1] ^ w_b_eff[BYTE_W-1]));

endmodule

// File: rtl/addsub_multibyte_seq.sv
// -----------------------------------------------------------------------------
// addsub_multibyte_seq
// Sequential W-bit add/subtract built from one 8-bit slice, processed least
// significant byte first with the carry chained through a register.
// Operands are latched on acceptance; the result is held until the consumer
// takes it and then retained until the next operation overwrites it.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   op_a, op_b, sub     : operands and operation select (1 = A-B)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   result              : A +/- B modulo 2^W
//   carry_out           : raw carry out of the MSB (sub: 1 = no borrow)
//   overflow            : signed two's-complement overflow
//   busy                : controller is not IDLE
// -----------------------------------------------------------------------------
module addsub_multibyte_seq
    import addsub_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int W      = BYTE_W * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         busy
);

    localparam int IDX_W = $clog2(NBYTES);

    if (!nbytes_ok(NBYTES)) begin : g_nbytes_check
        $error("addsub_multibyte_seq: NBYTES must be at least %0d", MIN_NBYTES);
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_sub;
    logic [W-1:0]       r_result;
    logic               r_carry_out;
    logic               r_overflow;

    logic               w_accept;
    logic               w_last;
    logic [BYTE_W-1:0]  w_a_byte;
    logic [BYTE_W-1:0]  w_b_byte;
    logic [BYTE_W-1:0]  w_sum;
    logic               w_cout;
    logic               w_c7;

    assign w_accept = (r_state == IDLE) & in_valid;
    assign w_last   = (r_idx == IDX_W'(NBYTES - 1));
    assign w_a_byte = r_a[BYTE_W*r_idx +: BYTE_W];
    assign w_b_byte = r_b[BYTE_W*r_idx +: BYTE_W];

    addsub_byte_slice u_slice (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .sub  (r_sub),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .c7   (w_c7)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand latch, byte iteration and result/flag capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= {IDX_W{1'b0}};
            r_carry     <= 1'b0;
            r_a         <= {W{1'b0}};
            r_b         <= {W{1'b0}};
            r_sub       <= 1'b0;
            r_result    <= {W{1'b0}};
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= sub;
            r_idx   <= {IDX_W{1'b0}};
            // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
            r_carry <= sub;
        end else if (r_state == RUN) begin
            r_result[BYTE_W*r_idx +: BYTE_W] <= w_sum;
            r_carry <= w_cout;
            if (w_last) begin
                r_idx       <= {IDX_W{1'b0}};
                r_carry_out <= w_cout;
                r_overflow  <= w_c7 ^ w_cout;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_idx <= r_idx;
        end
    end

    // Handshake/status outputs decode straight from the state register.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_addsub_multibyte_seq.sv
// -----------------------------------------------------------------------------
// Testbench for addsub_multibyte_seq (NBYTES = 4).
// Directed vectors with literal expectations, then randomized operations
// checked against an arithmetic reference model. A monitor checks result
// fields on every cycle out_valid is high.
// -----------------------------------------------------------------------------
module tb_addsub_multibyte_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    logic         exp_pending = 1'b0;
    logic [W+1:0] exp_v = '0;

    addsub_multibyte_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {overflow, carry_out, result} from plain arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         c;
        logic         ov;
        if (s) begin
            r  = a - b;
            c  = (a >= b);
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            t  = {1'b0, a} + {1'b0, b};
            r  = t[W-1:0];
            c  = t[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {ov, c, r};
    endfunction

    // Output monitor: whenever a result is offered it must be the expected one.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("valid_expected", {63'd0, exp_pending}, 64'd1);
            chk("outputs", {30'd0, overflow, carry_out, result}, {30'd0, exp_v});
            chk("done_status", {62'd0, busy, in_ready}, 64'd2);
        end
    end

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        if ($urandom_range(3, 0) == 0) return corner[$urandom_range(3, 0)];
        return $urandom;
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W+1:0] e, input int hold, input logic pre_ready,
                         output int acc);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        exp_v       = e;
        exp_pending = 1'b1;
        op_a        = a;
        op_b        = b;
        sub         = s;
        in_valid    = 1'b1;
        out_ready   = pre_ready;
        @(posedge clk); #1;
        acc      = edge_cnt;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        sub      = 1'($urandom_range(1, 0));
        n = 0;
        while (!out_valid && n < 50) begin
            in_valid = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(n), 64'(NB));
        if (!pre_ready) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom_range(1, 0));
                op_a     = $urandom;
                op_b     = $urandom;
                @(posedge clk); #1;
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready   = 1'b0;
        exp_pending = 1'b0;
        chk("released_valid", {63'd0, out_valid}, 64'd0);
        chk("released_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int acc1;
        int acc2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
        #12;
        chk("reset_outputs", {28'd0, out_valid, busy, carry_out, overflow, result},
            64'd0);
        #5 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_status", {62'd0, in_ready, busy}, 64'd2);

        // Pin the reference model against hand-computed values.
        chk("model_add", {30'd0, model(32'h0000_00FF, 32'h1, 1'b0)}, {30'd0, 2'b00, 32'h0000_0100});
        chk("model_sub_ovf", {30'd0, model(32'h8000_0000, 32'h1, 1'b1)}, {30'd0, 2'b11, 32'h7FFF_FFFF});

        // Directed vectors with literal expectations.
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, {2'b00, 32'h0000_0100}, 0, 1'b0, acc1);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {2'b01, 32'h0000_0000}, 1, 1'b0, acc1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {2'b10, 32'h8000_0000}, 0, 1'b0, acc1);
        do_op(32'h0000_0000, 32'h0000_0001, 1'b1, {2'b00, 32'hFFFF_FFFF}, 2, 1'b0, acc1);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, {2'b11, 32'h7FFF_FFFF}, 5, 1'b0, acc1);

        // Back-to-back throughput with out_ready held high.
        do_op(32'h0102_0304, 32'h0506_0708, 1'b0, {2'b00, 32'h0608_0A0C}, 0, 1'b1, acc1);
        do_op(32'h0000_0010, 32'h0000_0020, 1'b1, {2'b00, 32'hFFFF_FFF0}, 0, 1'b1, acc2);
        chk("throughput", 64'(acc2 - acc1), 64'(NB + 2));

        // Reset on the second RUN cycle aborts the operation.
        exp_v = {2'b00, 32'h0000_0000}; exp_pending = 1'b1;
        op_a = 32'hAAAA_AAAA; op_b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1; exp_pending = 1'b0;
        #1;
        chk("abort_outputs", {28'd0, out_valid, busy, carry_out, overflow, result}, 64'd0);
        #3 rst = 1'b0;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, {2'b00, 32'h2345_6789}, 0, 1'b0, acc1);

        // Randomized operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            ra = pick();
            rb = pick();
            rs = 1'($urandom_range(1, 0));
            do_op(ra, rb, rs, model(ra, rb, rs), int'($urandom_range(3, 0)),
                  1'($urandom_range(1, 0)), acc1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
